// File: rtl/sipo_stream.sv
// sipo_stream: serial-in/parallel-out shift buffer for beats of LANES {X,Y}
// records. DEPTH stages are presented in parallel, with ready/valid flow
// control on both sides, a fill counter, and a frame or sliding-window mode.
//
// Handshake: a beat transfers on a rising CLK edge where I_valid && I_ready;
// an output transfers where O_valid && O_ready. Valid is never withdrawn by
// the producer side of this block until the matching handshake occurs.
module sipo_stream #(
    parameter int LANES = 2,
    parameter int XW    = 1,
    parameter int YW    = 5,
    parameter int DEPTH = 5,
    parameter int MODE  = 0,
    parameter int CW    = 3
) (
    input  logic                      CLK,
    input  logic                      ASYNCRESETN,
    input  logic                      FLUSH,
    input  logic                      I_valid,
    output logic                      I_ready,
    input  logic [LANES*XW-1:0]       I_X,
    input  logic [LANES*YW-1:0]       I_Y,
    output logic                      O_valid,
    input  logic                      O_ready,
    output logic [DEPTH*LANES*XW-1:0] O_X,
    output logic [DEPTH*LANES*YW-1:0] O_Y,
    output logic [CW-1:0]             COUNT
);

    localparam int SXW = LANES * XW;
    localparam int SYW = LANES * YW;
    localparam int TXW = DEPTH * SXW;
    localparam int TYW = DEPTH * SYW;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [TXW-1:0] x_q, x_d;
    logic [TYW-1:0] y_q, y_d;
    logic [CW-1:0]  count_q, count_d;
    logic           fresh_q, fresh_d;

    logic           acc;
    logic           ohs;
    logic [CW-1:0]  count_inc;

    // A full, unconsumed buffer refuses input unless it is drained this edge.
    assign I_ready   = !fresh_q || O_ready;
    // FLUSH overrides an accept: nothing is shifted or counted.
    assign acc       = I_valid && I_ready && !FLUSH;
    assign ohs       = fresh_q && O_ready;
    assign count_inc = count_q + CW'(1);

    assign O_valid = fresh_q;
    assign O_X     = x_q;
    assign O_Y     = y_q;
    assign COUNT   = count_q;

    // Next-state: stage shift on accept, fill counter and fresh flag per mode.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        count_d = count_q;
        fresh_d = fresh_q;
        if (acc) begin
            // Stage 0 sits at the LSBs; the oldest stage falls off the top.
            x_d = {x_q[TXW-SXW-1:0], I_X};
            y_d = {y_q[TYW-SYW-1:0], I_Y};
        end
        if (FLUSH) begin
            count_d = '0;
            fresh_d = 1'b0;
        end else if (MODE == 0) begin
            if (acc && ohs) begin
                // Old frame leaves on this edge; the new beat starts a frame.
                count_d = CW'(1);
                fresh_d = 1'b0;
            end else if (acc) begin
                count_d = count_inc;
                fresh_d = (count_inc == FULL);
            end else if (ohs) begin
                count_d = '0;
                fresh_d = 1'b0;
            end
        end else begin
            if (acc) begin
                count_d = (count_q == FULL) ? count_q : count_inc;
                fresh_d = ((count_q == FULL) || (count_inc == FULL));
            end else if (ohs) begin
                fresh_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            x_q     <= '0;
            y_q     <= '0;
            count_q <= '0;
            fresh_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            count_q <= count_d;
            fresh_q <= fresh_d;
        end
    end

endmodule

// File: tb/tb_sipo_stream.sv
// Bench for sipo_stream: a frame-mode and a window-mode instance run side by
// side against a history-array reference model, with directed scenarios
// followed by randomized traffic.
module tb_sipo_stream;

    localparam int LANES = 2;
    localparam int XW    = 1;
    localparam int YW    = 5;
    localparam int DEPTH = 5;
    localparam int CW    = 3;
    localparam int SXW   = LANES * XW;
    localparam int SYW   = LANES * YW;
    localparam int TXW   = DEPTH * SXW;
    localparam int TYW   = DEPTH * SYW;

    logic           clk;
    logic           rst_n;
    logic           flush [2];
    logic           iv    [2];
    logic           ir    [2];
    logic [SXW-1:0] ix    [2];
    logic [SYW-1:0] iy    [2];
    logic           ov    [2];
    logic           ordy  [2];
    logic [TXW-1:0] ox    [2];
    logic [TYW-1:0] oy    [2];
    logic [CW-1:0]  cnt   [2];

    int n_chk = 0;
    int n_err = 0;

    // Reference model: beat history (index 0 newest), fill count, fresh flag.
    logic [SXW-1:0] hx [2][DEPTH];
    logic [SYW-1:0] hy [2][DEPTH];
    int             m_cnt   [2];
    bit             m_fresh [2];

    sipo_stream #(.LANES(LANES), .XW(XW), .YW(YW), .DEPTH(DEPTH), .MODE(0), .CW(CW)) u_frame (
        .CLK(clk), .ASYNCRESETN(rst_n), .FLUSH(flush[0]),
        .I_valid(iv[0]), .I_ready(ir[0]), .I_X(ix[0]), .I_Y(iy[0]),
        .O_valid(ov[0]), .O_ready(ordy[0]), .O_X(ox[0]), .O_Y(oy[0]), .COUNT(cnt[0])
    );

    sipo_stream #(.LANES(LANES), .XW(XW), .YW(YW), .DEPTH(DEPTH), .MODE(1), .CW(CW)) u_window (
        .CLK(clk), .ASYNCRESETN(rst_n), .FLUSH(flush[1]),
        .I_valid(iv[1]), .I_ready(ir[1]), .I_X(ix[1]), .I_Y(iy[1]),
        .O_valid(ov[1]), .O_ready(ordy[1]), .O_X(ox[1]), .O_Y(oy[1]), .COUNT(cnt[1])
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_cnt[m]   = 0;
            m_fresh[m] = 1'b0;
            for (int d = 0; d < DEPTH; d++) begin
                hx[m][d] = '0;
                hy[m][d] = '0;
            end
        end
    endtask

    // Apply the behavioural rules for one clock edge.
    task automatic model_step(input int m);
        bit rdy, acc, ohs;
        rdy = !m_fresh[m] || ordy[m];
        acc = iv[m] && rdy && !flush[m];
        ohs = m_fresh[m] && ordy[m];
        if (acc) begin
            for (int d = DEPTH - 1; d > 0; d--) begin
                hx[m][d] = hx[m][d-1];
                hy[m][d] = hy[m][d-1];
            end
            hx[m][0] = ix[m];
            hy[m][0] = iy[m];
        end
        if (flush[m]) begin
            m_cnt[m]   = 0;
            m_fresh[m] = 1'b0;
        end else if (m == 0) begin
            if (acc && ohs) begin
                m_cnt[m]   = 1;
                m_fresh[m] = 1'b0;
            end else if (acc) begin
                m_cnt[m]   = m_cnt[m] + 1;
                m_fresh[m] = (m_cnt[m] == DEPTH);
            end else if (ohs) begin
                m_cnt[m]   = 0;
                m_fresh[m] = 1'b0;
            end
        end else begin
            if (acc) begin
                m_cnt[m]   = (m_cnt[m] < DEPTH) ? m_cnt[m] + 1 : DEPTH;
                m_fresh[m] = (m_cnt[m] == DEPTH);
            end else if (ohs) begin
                m_fresh[m] = 1'b0;
            end
        end
    endtask

    function automatic logic [63:0] exp_x(input int m);
        logic [63:0] r;
        r = '0;
        for (int d = 0; d < DEPTH; d++) r[d*SXW +: SXW] = hx[m][d];
        return r;
    endfunction

    function automatic logic [63:0] exp_y(input int m);
        logic [63:0] r;
        r = '0;
        for (int d = 0; d < DEPTH; d++) r[d*SYW +: SYW] = hy[m][d];
        return r;
    endfunction

    // One clock: check I_ready before the edge, step model, check outputs after.
    task automatic tick();
        #1;
        for (int m = 0; m < 2; m++)
            chk($sformatf("m%0d_i_ready", m), 64'(ir[m]), 64'(!m_fresh[m] || ordy[m]));
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d_o_valid", m), 64'(ov[m]), 64'(m_fresh[m]));
            chk($sformatf("m%0d_count", m), 64'(cnt[m]), 64'(m_cnt[m]));
            chk($sformatf("m%0d_o_x", m), 64'(ox[m]), exp_x(m));
            chk($sformatf("m%0d_o_y", m), 64'(oy[m]), exp_y(m));
        end
    endtask

    task automatic drive_beat(input int m, input int v);
        iv[m] = 1'b1;
        ix[m] = {LANES{v[XW-1:0]}};
        iy[m] = {LANES{v[YW-1:0]}};
    endtask

    task automatic beat(input int m, input int v);
        drive_beat(m, v);
        tick();
        iv[m] = 1'b0;
    endtask

    task automatic idle_all();
        for (int m = 0; m < 2; m++) begin
            iv[m]    = 1'b0;
            flush[m] = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            flush[m] = 1'b0;
            iv[m]    = 1'b0;
            ix[m]    = '0;
            iy[m]    = '0;
            ordy[m]  = 1'b1;
        end
        model_reset();
        #2;
        for (int m = 0; m < 2; m++) begin
            chk("reset_o_valid", 64'(ov[m]), 64'(0));
            chk("reset_i_ready", 64'(ir[m]), 64'(1));
            chk("reset_count", 64'(cnt[m]), 64'(0));
            chk("reset_o_y", 64'(oy[m]), 64'(0));
        end
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame mode streaming, consumer always ready.
        for (int i = 1; i <= 10; i++) begin
            beat(0, i);
            if (i == 5 || i == 10) chk("frame_pulse", 64'(ov[0]), 64'(1));
            if (i == 5) begin
                chk("frame_s0_y", 64'(oy[0][4:0]), 64'(5));
                chk("frame_s4_y", 64'(oy[0][44:40]), 64'(1));
            end
            if (i == 6) chk("frame_count_restart", 64'(cnt[0]), 64'(1));
        end
        tick();

        // Frame mode backpressure.
        ordy[0] = 1'b0;
        for (int i = 1; i <= 5; i++) beat(0, i);
        drive_beat(0, 6);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_i_ready", 64'(ir[0]), 64'(0));
            chk("bp_hold_s0", 64'(oy[0][4:0]), 64'(5));
        end
        ordy[0] = 1'b1;
        tick();
        chk("bp_release_count", 64'(cnt[0]), 64'(1));
        chk("bp_release_s0", 64'(oy[0][4:0]), 64'(6));
        iv[0] = 1'b0;
        tick();

        // Window mode.
        for (int i = 1; i <= 8; i++) begin
            beat(1, i);
            if (i >= 5) chk("win_valid", 64'(ov[1]), 64'(1));
        end
        chk("win_s0_y", 64'(oy[1][4:0]), 64'(8));
        chk("win_s4_y", 64'(oy[1][44:40]), 64'(4));
        chk("win_count_sat", 64'(cnt[1]), 64'(5));
        ordy[1] = 1'b0;
        drive_beat(1, 9);
        tick();
        tick();
        chk("win_hold_ready", 64'(ir[1]), 64'(0));
        chk("win_hold_s0", 64'(oy[1][4:0]), 64'(8));
        iv[1]   = 1'b0;
        ordy[1] = 1'b1;
        tick();
        chk("win_drain_valid", 64'(ov[1]), 64'(0));
        chk("win_drain_count", 64'(cnt[1]), 64'(5));

        // FLUSH: beat presented together with FLUSH is dropped.
        flush[0] = 1'b1;
        flush[1] = 1'b1;
        tick();
        idle_all();
        for (int i = 1; i <= 3; i++) beat(0, i);
        flush[0] = 1'b1;
        drive_beat(0, 20);
        tick();
        idle_all();
        chk("flush_count", 64'(cnt[0]), 64'(0));
        chk("flush_no_shift", 64'(oy[0][4:0]), 64'(3));
        for (int i = 4; i <= 8; i++) begin
            beat(0, i);
            chk("flush_refill_valid", 64'(ov[0]), 64'(i == 8));
        end
        tick();

        // Asynchronous reset between edges with a partial frame.
        for (int i = 1; i <= 4; i++) beat(0, i);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_count", 64'(cnt[0]), 64'(0));
        chk("areset_o_y", 64'(oy[0]), 64'(0));
        chk("areset_o_x", 64'(ox[0]), 64'(0));
        chk("areset_i_ready", 64'(ir[0]), 64'(1));
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 5; i++) begin
            beat(0, i);
            chk("areset_refill_valid", 64'(ov[0]), 64'(i == 5));
        end

        // Randomized traffic on both instances.
        for (int k = 0; k < 400; k++) begin
            for (int m = 0; m < 2; m++) begin
                iv[m]    = ($urandom_range(0, 3) != 0);
                ordy[m]  = ($urandom_range(0, 2) != 0);
                flush[m] = ($urandom_range(0, 19) == 0);
                ix[m]    = SXW'($urandom);
                iy[m]    = SYW'($urandom);
            end
            tick();
        end
        idle_all();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
